regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Integer register file with a per-register pending-write scoreboard.
- Receives writeback-stage results and serves decode-stage operand reads.
- Reads bypass same-cycle writebacks.
- Tracks outstanding writes per destination register. Raises a stall when an operand, or a new destination, is not yet safe to use.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (x0 hardwired zero)
AW, 5, register address width, log2(NREG)
CNT_W, 2, width of each pending counter (max outstanding writes per register = 2^CNT_W-1)

Ports:
clk_i  input  1  clock, rising edge
reset_i  input  1  asynchronous, active-low reset
rs1_addr_i  input  AW  decode source-1 address
rs1_used_i  input  1  source 1 is consumed by the decoding instruction
rs2_addr_i  input  AW  decode source-2 address
rs2_used_i  input  1  source 2 is consumed by the decoding instruction
rs1_data_o  output  XLEN  source-1 operand (combinational, bypassed)
rs2_data_o  output  XLEN  source-2 operand (combinational, bypassed)
issue_en_i  input  1  decoding instruction issues this cycle and will write rd
issue_rd_i  input  AW  destination of issuing instruction
wb_en_i  input  1  writeback valid this cycle
wb_addr_i  input  AW  writeback destination
wb_data_i  input  XLEN  writeback data (register-file write data from the writeback stage)
cancel_en_i  input  1  a squashed in-flight instruction retires without writing
cancel_rd_i  input  AW  destination of squashed instruction
stall_o  output  1  decode must hold (combinational)
err_o  output  1  sticky scoreboard error flag (registered)

Behaviour:
- Reset (reset_i=0, async): all registers=0, all pending counters=0, err_o=0. rs*_data_o therefore read 0. stall_o=0 when no writeback is in flight.
- Register write: at posedge, if wb_en_i and wb_addr_i!=0, reg[wb_addr_i]<=wb_data_i. Writes to x0 are dropped.
- Read: rsN_data_o = 0 if addr==0.
  - Else wb_data_i if wb_en_i and wb_addr_i==addr (same-cycle bypass).
  - Else reg[addr].
- Pending counter cnt[r] is updated at posedge as cnt + inc - dec_wb - dec_cancel (each term 0/1):
  - inc = issue_en_i & issue_rd_i==r & !stall_o
  - dec_wb = wb_en_i & wb_addr_i==r
  - dec_cancel = cancel_en_i & cancel_rd_i==r
  - Net +1 / 0 / -1 / -2 are all legal.
  - cnt[0] is constant 0; issue, writeback and cancel to x0 are ignored.
- Underflow: if the decrement exceeds cnt, the counter clamps to 0 and err_o<=1. The register write still occurs.
- Overflow: handled by the stall; an issue is never accepted at cnt==max.
- Effective pending for source address a: eff(a) = cnt[a] - dec_wb(a) - dec_cancel(a), evaluated in the current cycle (signed, clamp at 0). Source is busy when eff(a)>0.
- stall_o = (rs1_used_i & busy(rs1)) | (rs2_used_i & busy(rs2)) | (issue_en_i & issue_rd_i!=0 & cnt[issue_rd_i]==2^CNT_W-1 & !dec(issue_rd_i)).
- Zero-latency resolution: in the cycle the last pending write arrives, stall_o=0 and the operand is taken from the bypass path.
- Issue to the same rd as its own source (e.g. add x5,x5,x1) checks sources before the increment. Not self-stalling.
- err_o is sticky and cleared only by reset.
- Reset mid-operation: all state clears immediately. In-flight writebacks after reset release are errors only if they underflow.

Test Plan:
- Reset, then read x0..x31 -> all data 0, stall_o=0, err_o=0. Write x0=0xDEADBEEF -> x0 still reads 0.
- issue rd=x5. Next cycle, read rs1=x5 used -> stall_o=1. Cycle with wb x5=0x12345678 -> stall_o=0, rs1_data_o=0x12345678 same cycle. Following cycle reg[5]=0x12345678, cnt[5]=0.
- Issue x7 three times (cnt=3), fourth issue x7 with no wb -> stall_o=1, cnt stays 3. Repeat with wb x7 same cycle -> stall_o=0, cnt stays 3.
- cnt[9]=1. Cancel x9 same cycle as read rs2=x9 used -> stall_o=0, rs2_data_o=old reg[9]. cnt[9]=0, no write.
- cnt[4]=0. wb x4=0xA5A5A5A5 -> reg[4]=0xA5A5A5A5, cnt[4]=0, err_o=1 and remains 1 until reset_i=0.
- With cnt[3]=2, assert reset_i=0 mid-cycle -> cnt and registers 0 immediately, err_o=0, stall_o deasserts without a clock edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Integer register file (x0 reads as zero) with a per-register
//   pending-write scoreboard. Decode reads two operands through a
//   same-cycle writeback bypass. Each register keeps a small counter of
//   outstanding writes, and decode is stalled while an operand (or a
//   saturated destination) is not yet safe to use.
//
// Ports
//   clk_i         clock, rising edge
//   reset_i       asynchronous active-low reset
//   rs1_addr_i    decode source-1 address
//   rs1_used_i    source 1 consumed by the decoding instruction
//   rs2_addr_i    decode source-2 address
//   rs2_used_i    source 2 consumed by the decoding instruction
//   rs1_data_o    source-1 operand (combinational, bypassed)
//   rs2_data_o    source-2 operand (combinational, bypassed)
//   issue_en_i    decoding instruction issues and will write issue_rd_i
//   issue_rd_i    destination of the issuing instruction
//   wb_en_i       writeback valid
//   wb_addr_i     writeback destination
//   wb_data_i     writeback data
//   cancel_en_i   squashed in-flight instruction retires without writing
//   cancel_rd_i   destination of the squashed instruction
//   stall_o       decode must hold (combinational)
//   err_o         sticky scoreboard underflow flag (registered)

module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 2
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic            rs1_used_i,
  input  logic [AW-1:0]   rs2_addr_i,
  input  logic            rs2_used_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            issue_en_i,
  input  logic [AW-1:0]   issue_rd_i,
  input  logic            wb_en_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            cancel_en_i,
  input  logic [AW-1:0]   cancel_rd_i,
  output logic            stall_o,
  output logic            err_o
);

  localparam int CW1 = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  regs    [NREG];
  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];

  logic [NREG-1:0] dec_wb_v;
  logic [NREG-1:0] dec_cn_v;
  logic [NREG-1:0] inc_v;
  logic [NREG-1:0] uf_v;

  logic rs1_busy;
  logic rs2_busy;
  logic rd_full;
  logic err_q;

  // Per-register decrement requests this cycle; x0 never tracks anything.
  always_comb begin
    dec_wb_v = '0;
    dec_cn_v = '0;
    for (int r = 1; r < NREG; r++) begin
      dec_wb_v[r] = wb_en_i     && (wb_addr_i   == AW'(r));
      dec_cn_v[r] = cancel_en_i && (cancel_rd_i == AW'(r));
    end
  end

  // A source is busy when writes remain outstanding after this cycle's
  // writeback/cancel retire, so the last arriving write resolves with
  // zero latency through the bypass.
  always_comb begin
    rs1_busy = {1'b0, cnt[rs1_addr_i]} >
               (CW1'(dec_wb_v[rs1_addr_i]) + CW1'(dec_cn_v[rs1_addr_i]));
    rs2_busy = {1'b0, cnt[rs2_addr_i]} >
               (CW1'(dec_wb_v[rs2_addr_i]) + CW1'(dec_cn_v[rs2_addr_i]));
    // A saturated counter can still take an issue if it drains this cycle.
    rd_full  = issue_en_i && (issue_rd_i != '0) &&
               (cnt[issue_rd_i] == CNT_MAX) &&
               !(dec_wb_v[issue_rd_i] || dec_cn_v[issue_rd_i]);
    stall_o  = (rs1_used_i && rs1_busy) || (rs2_used_i && rs2_busy) || rd_full;
  end

  // Counter next-state. Sources are checked against the pre-increment
  // count, so an instruction reading its own destination never self-stalls.
  always_comb begin
    inc_v      = '0;
    uf_v       = '0;
    cnt_nxt[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      logic [CW1-1:0] up;
      logic [CW1-1:0] down;
      inc_v[r]   = issue_en_i && (issue_rd_i == AW'(r)) && !stall_o;
      up         = {1'b0, cnt[r]} + CW1'(inc_v[r]);
      down       = CW1'(dec_wb_v[r]) + CW1'(dec_cn_v[r]);
      cnt_nxt[r] = '0;
      if (down > up) begin
        uf_v[r] = 1'b1;
      end else begin
        cnt_nxt[r] = CNT_W'(up - down);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      if (|uf_v) begin
        err_q <= 1'b1;
      end
    end
  end

  // Register array; an underflowing writeback still updates the register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (wb_en_i && (wb_addr_i != '0)) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  end

  always_comb begin
    if (rs1_addr_i == '0) begin
      rs1_data_o = '0;
    end else if (wb_en_i && (wb_addr_i == rs1_addr_i)) begin
      rs1_data_o = wb_data_i;
    end else begin
      rs1_data_o = regs[rs1_addr_i];
    end

    if (rs2_addr_i == '0) begin
      rs2_data_o = '0;
    end else if (wb_en_i && (wb_addr_i == rs2_addr_i)) begin
      rs2_data_o = wb_data_i;
    end else begin
      rs2_data_o = regs[rs2_addr_i];
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: linear stimulus, immediate
// assertions against hand-computed expectations.

module tb_regfile_scoreboard;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, issue_rd_i, wb_addr_i, cancel_rd_i;
  logic        rs1_used_i, rs2_used_i, issue_en_i, wb_en_i, cancel_en_i;
  logic [31:0] wb_data_i;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic        stall_o, err_o;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .rs1_addr_i  (rs1_addr_i),
    .rs1_used_i  (rs1_used_i),
    .rs2_addr_i  (rs2_addr_i),
    .rs2_used_i  (rs2_used_i),
    .rs1_data_o  (rs1_data_o),
    .rs2_data_o  (rs2_data_o),
    .issue_en_i  (issue_en_i),
    .issue_rd_i  (issue_rd_i),
    .wb_en_i     (wb_en_i),
    .wb_addr_i   (wb_addr_i),
    .wb_data_i   (wb_data_i),
    .cancel_en_i (cancel_en_i),
    .cancel_rd_i (cancel_rd_i),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1_addr_i = '0; rs1_used_i = 0; rs2_addr_i = '0; rs2_used_i = 0;
    issue_en_i = 0;  issue_rd_i = '0;
    wb_en_i = 0;     wb_addr_i = '0; wb_data_i = '0;
    cancel_en_i = 0; cancel_rd_i = '0;
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle(); issue_en_i = 1; issue_rd_i = rd; tick();
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    idle(); wb_en_i = 1; wb_addr_i = rd; wb_data_i = d; tick();
  endtask

  initial begin
    idle();
    reset_i = 0;
    #2;
    for (int a = 0; a < 32; a++) begin
      rs1_addr_i = 5'(a); rs2_addr_i = 5'(31 - a); #1;
      check("reset_rs1", rs1_data_o, 32'h0);
      check("reset_rs2", rs2_data_o, 32'h0);
    end
    rs1_used_i = 1; rs2_used_i = 1; #1;
    check("reset_stall", {31'b0, stall_o}, 32'h0);
    check("reset_err", {31'b0, err_o}, 32'h0);
    idle();
    #10 reset_i = 1;
    tick();

    // x0 write dropped, also on the bypass path
    idle(); wb_en_i = 1; wb_addr_i = 0; wb_data_i = 32'hDEADBEEF; rs1_addr_i = 0; #1;
    check("x0_bypass", rs1_data_o, 32'h0);
    tick();
    idle(); rs1_addr_i = 0; #1;
    check("x0_read", rs1_data_o, 32'h0);
    check("x0_err", {31'b0, err_o}, 32'h0);

    // issue x5, stall on read, zero-latency resolve via bypass
    idle(); issue_en_i = 1; issue_rd_i = 5; #1;
    check("issue5_nostall", {31'b0, stall_o}, 32'h0);
    tick();
    idle(); rs1_addr_i = 5; rs1_used_i = 1; #1;
    check("x5_pending_stall", {31'b0, stall_o}, 32'h1);
    wb_en_i = 1; wb_addr_i = 5; wb_data_i = 32'h12345678; #1;
    check("x5_wb_stall", {31'b0, stall_o}, 32'h0);
    check("x5_bypass", rs1_data_o, 32'h12345678);
    tick();
    idle(); rs1_addr_i = 5; rs1_used_i = 1; #1;
    check("x5_reg", rs1_data_o, 32'h12345678);
    check("x5_cnt0", {31'b0, stall_o}, 32'h0);

    // add x5,x5,x1 style issue: source checked before increment
    idle(); rs1_addr_i = 5; rs1_used_i = 1; issue_en_i = 1; issue_rd_i = 5; #1;
    check("self_issue", {31'b0, stall_o}, 32'h0);
    tick();
    idle(); rs2_addr_i = 5; rs2_used_i = 1; #1;
    check("self_issue_pend", {31'b0, stall_o}, 32'h1);
    wb(5, 32'h55555555);

    // saturate x7 at 3
    issue(7); issue(7); issue(7);
    idle(); issue_en_i = 1; issue_rd_i = 7; #1;
    check("x7_full_stall", {31'b0, stall_o}, 32'h1);
    tick();
    idle(); issue_en_i = 1; issue_rd_i = 7; wb_en_i = 1; wb_addr_i = 7; wb_data_i = 32'h77; #1;
    check("x7_full_wb", {31'b0, stall_o}, 32'h0);
    tick();
    wb(7, 32'h71); wb(7, 32'h72);
    idle(); rs1_addr_i = 7; rs1_used_i = 1; #1;
    check("x7_cnt1", {31'b0, stall_o}, 32'h1);
    wb_en_i = 1; wb_addr_i = 7; wb_data_i = 32'h73; #1;
    check("x7_last_wb", {31'b0, stall_o}, 32'h0);
    check("x7_bypass", rs1_data_o, 32'h73);
    tick();
    idle(); rs1_addr_i = 7; rs1_used_i = 1; #1;
    check("x7_cnt0", {31'b0, stall_o}, 32'h0);
    check("x7_err", {31'b0, err_o}, 32'h0);

    // cancel x9 resolves the read with the old value
    issue(9); wb(9, 32'h99999999); issue(9);
    idle(); rs2_addr_i = 9; rs2_used_i = 1; #1;
    check("x9_pending", {31'b0, stall_o}, 32'h1);
    cancel_en_i = 1; cancel_rd_i = 9; #1;
    check("x9_cancel_stall", {31'b0, stall_o}, 32'h0);
    check("x9_cancel_data", rs2_data_o, 32'h99999999);
    tick();
    idle(); rs2_addr_i = 9; rs2_used_i = 1; #1;
    check("x9_cnt0", {31'b0, stall_o}, 32'h0);
    check("x9_nowrite", rs2_data_o, 32'h99999999);
    check("x9_err", {31'b0, err_o}, 32'h0);

    // underflow on x4: write happens, err sticks
    idle(); wb_en_i = 1; wb_addr_i = 4; wb_data_i = 32'hA5A5A5A5; #1;
    check("uf_err_before_edge", {31'b0, err_o}, 32'h0);
    tick();
    idle(); rs1_addr_i = 4; rs1_used_i = 1; #1;
    check("uf_reg", rs1_data_o, 32'hA5A5A5A5);
    check("uf_cnt0", {31'b0, stall_o}, 32'h0);
    check("uf_err", {31'b0, err_o}, 32'h1);
    tick(); tick();
    check("uf_err_sticky", {31'b0, err_o}, 32'h1);

    // reset mid-operation with cnt[3]=2
    issue(3); issue(3);
    idle(); rs1_addr_i = 3; rs1_used_i = 1; rs2_addr_i = 4; #1;
    check("x3_pending", {31'b0, stall_o}, 32'h1);
    @(negedge clk_i);
    #2 reset_i = 0; #1;
    check("rst_stall", {31'b0, stall_o}, 32'h0);
    check("rst_err", {31'b0, err_o}, 32'h0);
    check("rst_reg4", rs2_data_o, 32'h0);
    #10 reset_i = 1;
    tick();
    idle(); wb_en_i = 1; wb_addr_i = 3; wb_data_i = 32'h33; #1;
    check("late_wb_err_pre", {31'b0, err_o}, 32'h0);
    tick();
    idle(); rs1_addr_i = 3; #1;
    check("late_wb_err", {31'b0, err_o}, 32'h1);
    check("late_wb_reg", rs1_data_o, 32'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
